// File: rtl/wash_pkg.sv
// Shared encodings and helpers for the washing-machine sequencer.
package wash_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] IDLE  = 3'd0;
    localparam logic [MODE_W-1:0] FILL  = 3'd1;
    localparam logic [MODE_W-1:0] WASH  = 3'd2;
    localparam logic [MODE_W-1:0] DRAIN = 3'd3;
    localparam logic [MODE_W-1:0] RINSE = 3'd4;
    localparam logic [MODE_W-1:0] SPIN  = 3'd5;
    localparam logic [MODE_W-1:0] FAULT = 3'd7;

    // Rinse count for a programme: prog+1, clamped to max_rinse.
    function automatic logic [2:0] rinse_clamp(input logic [1:0] prog, input int max_rinse);
        int n;
        n = int'(prog) + 1;
        if (n > max_rinse) n = max_rinse;
        return 3'(n);
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable phase down-counter; stops at zero, clear beats load beats decrement.
module wash_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        count <= '0;
        else if (clear)                 count <= '0;
        else if (load)                  count <= load_val;
        else if (!hold && count != '0)  count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wash_seq_ctrl.sv
// Washing-machine sequencer: FILL/WASH/(DRAIN/RINSE)xN/DRAIN/SPIN with pause and door fault.
// Define WASH_CYCLE_CNT_EN to add the saturating completed-programme counter cycle_count.
module wash_seq_ctrl
    import wash_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int FILL_CYC  = 4,
    parameter int WASH_CYC  = 10,
    parameter int DRAIN_CYC = 3,
    parameter int RINSE_CYC = 6,
    parameter int SPIN_CYC  = 8,
    parameter int MAX_RINSE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              door_open,
    input  logic [1:0]        prog,
    output logic [MODE_W-1:0] mode,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [CNT_W-1:0]  remaining,
    output logic [2:0]        rinse_left
`ifdef WASH_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycle_count
`endif
);

    logic [MODE_W-1:0] state_nxt;
    logic [2:0]        rinse_nxt;
    logic              recov, recov_nxt;
    logic              t_load, t_hold, t_clear, zero;
    logic [CNT_W-1:0]  t_val;
    logic              busy_nxt, paused_nxt, done_nxt;
    logic              active;

    function automatic logic [CNT_W-1:0] dur_m1(input logic [MODE_W-1:0] m);
        case (m)
            FILL:    return CNT_W'(FILL_CYC - 1);
            WASH:    return CNT_W'(WASH_CYC - 1);
            DRAIN:   return CNT_W'(DRAIN_CYC - 1);
            RINSE:   return CNT_W'(RINSE_CYC - 1);
            SPIN:    return CNT_W'(SPIN_CYC - 1);
            default: return '0;
        endcase
    endfunction

    assign active = (mode == FILL) || (mode == WASH) || (mode == DRAIN) ||
                    (mode == RINSE) || (mode == SPIN);

    wash_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .hold     (t_hold),
        .clear    (t_clear),
        .count    (remaining),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= IDLE;
            rinse_left <= '0;
            recov      <= 1'b0;
        end else begin
            mode       <= state_nxt;
            rinse_left <= rinse_nxt;
            recov      <= recov_nxt;
        end
    end

    always_comb begin
        state_nxt = mode;
        rinse_nxt = rinse_left;
        recov_nxt = recov;
        t_load    = 1'b0;
        t_val     = '0;
        t_hold    = 1'b1;
        t_clear   = 1'b0;
        case (mode)
            IDLE: begin
                if (start && !door_open) begin
                    state_nxt = FILL;
                    rinse_nxt = rinse_clamp(prog, MAX_RINSE);
                end
            end
            FILL, WASH, DRAIN, RINSE, SPIN: begin
                // Pause outranks the door so the door may be opened while paused.
                if (pause) begin
                    state_nxt = mode;
                end else if (door_open) begin
                    state_nxt = FAULT;
                end else if (!zero) begin
                    t_hold = 1'b0;
                end else begin
                    case (mode)
                        FILL:  state_nxt = WASH;
                        WASH:  state_nxt = DRAIN;
                        DRAIN: state_nxt = recov ? IDLE : (rinse_left != '0) ? RINSE : SPIN;
                        RINSE: begin
                            state_nxt = DRAIN;
                            rinse_nxt = rinse_left - 3'd1;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            FAULT: begin
                if (start && !door_open) begin
                    state_nxt = DRAIN;
                    recov_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE) begin
            rinse_nxt = '0;
            recov_nxt = 1'b0;
            t_clear   = 1'b1;
        end else if (state_nxt == FAULT) begin
            t_clear = 1'b1;
        end else if (state_nxt != mode) begin
            t_load = 1'b1;
            t_val  = dur_m1(state_nxt);
        end
    end

    // SPIN only leaves to IDLE on expiry, so that transition is the normal completion.
    always_comb begin
        busy_nxt   = (state_nxt != IDLE);
        paused_nxt = active && pause;
        done_nxt   = (mode == SPIN) && (state_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            paused <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            paused <= paused_nxt;
            done   <= done_nxt;
        end
    end

`ifdef WASH_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   cycle_count <= '0;
        else if (done_nxt && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
    end
`endif

endmodule

// File: doc/wash_seq_ctrl.md
Name: wash_seq_ctrl

Overview:
Second-generation washing-machine sequencer. Phase durations are parametrised. The rinse/drain loop count is selectable per programme. It adds pause/resume, a door-interlock fault and programme-complete signalling. It sits between the front-panel logic (start/pause/door/programme) and the actuator drivers, which decode mode.

Parameters:
CNT_W, 8, width of the phase down-counter and of remaining
FILL_CYC, 4, FILL phase length in cycles (1..2^CNT_W-1)
WASH_CYC, 10, WASH phase length
DRAIN_CYC, 3, DRAIN phase length
RINSE_CYC, 6, RINSE phase length
SPIN_CYC, 8, SPIN phase length
MAX_RINSE, 4, upper clamp on the rinse count (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; starts a programme from IDLE or acknowledges FAULT
pause  in  1  level; freezes the sequence while high
door_open  in  1  level; door sensor
prog  in  2  programme select; rinse count = min(prog+1, MAX_RINSE)
mode  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 7 FAULT
busy  out  1  high in any state other than IDLE
paused  out  1  high while busy, not FAULT, and pause=1
done  out  1  one-cycle pulse on normal completion
remaining  out  CNT_W  cycles left in current phase, minus one; 0 in IDLE/FAULT
rinse_left  out  3  rinses still to run, including the current one

Behaviour:
- Reset (async): mode=IDLE, busy=0, paused=0, done=0, remaining=0, rinse_left=0, latched programme=0. A reset mid-programme aborts immediately, with no done pulse.
- All outputs are registered. mode is the state register.
- IDLE:
  - start=1 with door_open=0 → FILL on the next edge.
  - prog is latched into rinse_left = min(prog+1, MAX_RINSE).
  - start with door_open=1 is ignored.
- Phase timing:
  - On phase entry the counter loads DUR-1. It decrements each active cycle.
  - Counter==0 on an active cycle → next phase. Every phase therefore lasts exactly DUR active cycles.
  - remaining mirrors the counter.
- Sequence: FILL → WASH → DRAIN → RINSE → DRAIN → ...
  - After each DRAIN: if rinse_left≠0 → RINSE, else → SPIN.
  - rinse_left decrements on RINSE exit.
  - The first DRAIN (after WASH) always goes to RINSE.
- SPIN expiry → IDLE. done=1 for exactly that first IDLE cycle.
- Default programme (prog=0) with default parameters totals 4+10+3+6+3+8 = 34 active cycles.
- Pause:
  - pause=1 in any active phase: state, counter and rinse_left hold; paused=1.
  - door_open is permitted while paused.
  - Resume when pause=0 and door_open=0. The counter continues from the held value.
- Door interlock:
  - An active phase with pause=0 and door_open=1 → FAULT on the next edge.
  - pause=1 and door_open=1 rising in the same cycle → pause wins, no fault.
- FAULT: counter cleared; busy=1.
  - start=1 with door_open=0 → DRAIN for DRAIN_CYC cycles (water evacuation), then IDLE with no done pulse.
  - start with door open is ignored.
  - A recovery DRAIN is flagged internally so it never branches to RINSE/SPIN.
- start while busy, outside FAULT, is ignored. prog changes after latch are ignored.
- Illegal state encodings (6) → IDLE on the next edge.
- DUR=1: the phase lasts one cycle and remaining stays 0.

Optional Feature:
Macro WASH_CYCLE_CNT_EN.
- Defined: adds output cycle_count[15:0], which counts done pulses.
  - Resets to 0 on rst.
  - Saturates at 16'hFFFF.
  - Faulted or reset-aborted programmes are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package wash_pkg holds:
  - the mode/state localparams: IDLE, FILL, WASH, DRAIN, RINSE, SPIN, FAULT
  - MODE_W=3
  - the rinse-count clamp function
- One sub-module, wash_phase_timer:
  - CNT_W-bit loadable down-counter
  - inputs: load, load_val, hold, clear
  - outputs: count, zero flag
  - The top-level FSM instantiates it once.

Test Plan:
- Reset high mid-WASH, then release → mode=0, busy=0, remaining=0; no done pulse; restart works normally.
- prog=0, start pulse, door closed → mode sequence 1×4, 2×10, 3×3, 4×6, 3×3, 5×8, then IDLE with done=1 for one cycle; 34 active cycles; remaining counts 3,2,1,0 in FILL.
- prog=3 (MAX_RINSE=4) → four RINSE/DRAIN pairs; rinse_left 4→1; total 4+10+3+4×(6+3)+8 = 61 cycles.
- pause held for 5 cycles during WASH, remaining=6 → mode=2, remaining=6, paused=1 for all 5 cycles; door opened and closed during the pause → no FAULT; WASH completes 7 active cycles after release.
- door_open=1 during RINSE, pause=0 → mode=7 next cycle; start with door open is ignored; door closed + start → DRAIN 3 cycles → IDLE, done=0.
- start while in SPIN, and prog changed mid-programme → no effect on sequence or timing; with WASH_CYCLE_CNT_EN, cycle_count increments by 1 per completed programme only.
